// File: rtl/exe_muldiv.sv
// Iterative RV64M multiply/divide unit for the execute stage.
// Multiplies by radix-2 shift-add and divides by radix-2 restoring
// shift-subtract. One iteration per cycle. Divide-by-zero and signed
// overflow are resolved directly from the operands without iterating.
module exe_muldiv #(
    parameter int XLEN   = 64,
    parameter int ITER_W = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            exe_flush,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic            is_word,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [XLEN-1:0]   ZERO_X   = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]   ONES_X   = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]   MIN_X    = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]   MIN_W    = {{(XLEN-31){1'b1}}, 31'b0};
    localparam logic [ITER_W-1:0] CNT_FULL = ITER_W'(XLEN);
    localparam logic [ITER_W-1:0] CNT_WORD = ITER_W'(XLEN/2);
    localparam logic [ITER_W-1:0] CNT_ONE  = ITER_W'(1);
    localparam logic [ITER_W-1:0] CNT_ZERO = ITER_W'(0);

    // Sign-extend the low 32 bits to the full datapath width.
    function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] v);
        return {{(XLEN-32){v[31]}}, v[31:0]};
    endfunction

    // Zero-extend the low 32 bits to the full datapath width.
    function automatic logic [XLEN-1:0] zext_word(input logic [XLEN-1:0] v);
        return {{(XLEN-32){1'b0}}, v[31:0]};
    endfunction

    // State and datapath registers
    state_t              state_r;
    logic [ITER_W-1:0]   cnt_r;
    logic [2*XLEN-1:0]   acc_r;      // product / {remainder, quotient}
    logic [XLEN-1:0]     opb_r;      // multiplicand or divisor magnitude
    logic [2:0]          funct3_r;
    logic                word_r;
    logic                neg_r;      // final result must be negated

    // Operand preparation signals
    logic                signed1_s;
    logic                signed2_s;
    logic [XLEN-1:0]     op1_s;
    logic [XLEN-1:0]     op2_s;
    logic                neg1_s;
    logic                neg2_s;
    logic [XLEN-1:0]     mag1_s;
    logic [XLEN-1:0]     mag2_s;
    logic                is_div_s;
    logic                div_zero_s;
    logic                div_ovf_s;
    logic                special_s;
    logic [XLEN-1:0]     special_raw_s;
    logic [XLEN-1:0]     special_res_s;
    logic                start_neg_s;
    logic [2*XLEN-1:0]   init_acc_s;
    logic [XLEN-1:0]     init_opb_s;

    // Iteration and finalisation signals
    logic [XLEN:0]       sum_s;
    logic [XLEN:0]       trial_s;
    logic [2*XLEN-1:0]   acc_next_s;
    logic [2*XLEN-1:0]   prod_s;
    logic [XLEN-1:0]     quo_s;
    logic [XLEN-1:0]     quo_f_s;
    logic [XLEN-1:0]     rem_f_s;
    logic [XLEN-1:0]     final_raw_s;
    logic [XLEN-1:0]     final_s;

    // Decode operand signedness from funct3; MUL is treated as signed
    // because its low half is identical either way.
    always_comb begin
        signed1_s = 1'b0;
        signed2_s = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                signed1_s = 1'b1;
                signed2_s = 1'b1;
            end
            3'b010: begin
                signed1_s = 1'b1;
                signed2_s = 1'b0;
            end
            default: begin
                signed1_s = 1'b0;
                signed2_s = 1'b0;
            end
        endcase
    end

    // Extend W operands, take magnitudes and record operand signs.
    always_comb begin
        if (is_word) begin
            op1_s = signed1_s ? sext_word(src1) : zext_word(src1);
            op2_s = signed2_s ? sext_word(src2) : zext_word(src2);
        end else begin
            op1_s = src1;
            op2_s = src2;
        end
        neg1_s = signed1_s & op1_s[XLEN-1];
        neg2_s = signed2_s & op2_s[XLEN-1];
        mag1_s = neg1_s ? (ZERO_X - op1_s) : op1_s;
        mag2_s = neg2_s ? (ZERO_X - op2_s) : op2_s;
    end

    // Detect divide special cases and form their results straight from the operands.
    always_comb begin
        is_div_s   = funct3[2];
        div_zero_s = is_div_s & (op2_s == ZERO_X);
        div_ovf_s  = is_div_s & ~funct3[0] & (op2_s == ONES_X) &
                     (op1_s == (is_word ? MIN_W : MIN_X));
        special_s  = div_zero_s | div_ovf_s;
        if (div_zero_s) begin
            special_raw_s = funct3[1] ? op1_s : ONES_X;
        end else if (div_ovf_s) begin
            special_raw_s = funct3[1] ? ZERO_X : op1_s;
        end else begin
            special_raw_s = ZERO_X;
        end
        special_res_s = is_word ? sext_word(special_raw_s) : special_raw_s;
    end

    // Choose the result sign and the initial accumulator layout for an iterative op.
    always_comb begin
        if (is_div_s) begin
            start_neg_s = funct3[1] ? neg1_s : (neg1_s ^ neg2_s);
            init_opb_s  = mag2_s;
            if (is_word) begin
                // Dividend sits at the top of the low half so 32 shifts consume it.
                init_acc_s = {ZERO_X, mag1_s[31:0], 32'b0};
            end else begin
                init_acc_s = {ZERO_X, mag1_s};
            end
        end else begin
            start_neg_s = neg1_s ^ neg2_s;
            init_opb_s  = mag1_s;
            init_acc_s  = {ZERO_X, mag2_s};
        end
    end

    // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide.
    always_comb begin
        sum_s   = {1'b0, acc_r[2*XLEN-1:XLEN]} +
                  (acc_r[0] ? {1'b0, opb_r} : {(XLEN+1){1'b0}});
        trial_s = acc_r[2*XLEN-1:XLEN-1] - {1'b0, opb_r};
        if (funct3_r[2]) begin
            if (!trial_s[XLEN]) begin
                acc_next_s = {trial_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
            end else begin
                acc_next_s = {acc_r[2*XLEN-2:0], 1'b0};
            end
        end else begin
            acc_next_s = {sum_s, acc_r[XLEN-1:1]};
        end
    end

    // Apply sign correction and select the architectural result after the last step.
    always_comb begin
        prod_s  = neg_r ? ({(2*XLEN){1'b0}} - acc_next_s) : acc_next_s;
        quo_s   = word_r ? zext_word(acc_next_s[XLEN-1:0]) : acc_next_s[XLEN-1:0];
        quo_f_s = neg_r ? (ZERO_X - quo_s) : quo_s;
        rem_f_s = neg_r ? (ZERO_X - acc_next_s[2*XLEN-1:XLEN])
                        : acc_next_s[2*XLEN-1:XLEN];
        if (funct3_r[2]) begin
            final_raw_s = funct3_r[1] ? rem_f_s : quo_f_s;
        end else if (word_r) begin
            // 32 iterations leave the product shifted up by 32 bits.
            final_raw_s = {{(XLEN-32){1'b0}}, prod_s[63:32]};
        end else if (funct3_r[1:0] == 2'b00) begin
            final_raw_s = prod_s[XLEN-1:0];
        end else begin
            final_raw_s = prod_s[2*XLEN-1:XLEN];
        end
        final_s = word_r ? sext_word(final_raw_s) : final_raw_s;
    end

    // Control FSM with registered busy/result_valid/result; flush wins over start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= CNT_ZERO;
            acc_r        <= {(2*XLEN){1'b0}};
            opb_r        <= ZERO_X;
            funct3_r     <= 3'b000;
            word_r       <= 1'b0;
            neg_r        <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result       <= ZERO_X;
        end else if (exe_flush) begin
            state_r      <= ST_IDLE;
            cnt_r        <= CNT_ZERO;
            busy         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    result_valid <= 1'b0;
                    if (start) begin
                        funct3_r <= funct3;
                        word_r   <= is_word;
                        neg_r    <= start_neg_s;
                        busy     <= 1'b1;
                        if (special_s) begin
                            result       <= special_res_s;
                            result_valid <= 1'b1;
                            state_r      <= ST_DONE;
                        end else begin
                            acc_r   <= init_acc_s;
                            opb_r   <= init_opb_s;
                            cnt_r   <= is_word ? CNT_WORD : CNT_FULL;
                            state_r <= ST_BUSY;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    acc_r <= acc_next_s;
                    cnt_r <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        result       <= final_s;
                        result_valid <= 1'b1;
                        state_r      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // The start still high here belongs to the completing op.
                    result_valid <= 1'b0;
                    busy         <= 1'b0;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    busy         <= 1'b0;
                    result_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
